// File: rtl/softermax_pkg.sv
// softermax_pkg
// Shared helpers for the softermax local-window datapath:
//   - out_max_width  : width of the signed integer local max (one extra bit so
//                      that the ceiling of the largest logit, e.g. 7.9375 -> 8,
//                      still fits).
//   - pow2_lut_entry : one entry of the 2^(f/2^frac_w) table, scaled to
//                      val_w-1 fraction bits and rounded half-up.
// Both functions are evaluated at elaboration time only.
package softermax_pkg;

    function automatic int out_max_width(input int in_w, input int frac_w);
        return in_w - frac_w + 1;
    endfunction

    function automatic int pow2_lut_entry(input int f, input int frac_w, input int val_w);
        real expo;
        real scaled;
        expo   = real'(f) / real'(1 << frac_w);
        scaled = (2.0 ** expo) * (2.0 ** real'(val_w - 1));
        return int'($floor(scaled + 0.5));
    endfunction

endpackage

// File: rtl/softermax_pow2_shift.sv
// softermax_pow2_shift
// Combinational 2^d for one lane, where d <= 0 is a signed fixed-point value
// with IN_FRAC_WIDTH fraction bits. d is split into an integer part q (floor)
// and a fraction f; the result is LUT[f] >> -q, flushed to zero once the
// shift reaches the output width.
// Ports:
//   diff  in  [DIFF_WIDTH-1:0]       signed difference x_i - max
//   value out [OUT_VALUE_WIDTH-1:0]  unsigned, OUT_VALUE_WIDTH-1 fraction bits
module softermax_pow2_shift
    import softermax_pkg::*;
#(
    parameter int IN_FRAC_WIDTH   = 4,
    parameter int OUT_VALUE_WIDTH = 16,
    parameter int DIFF_WIDTH      = 10
) (
    input  logic [DIFF_WIDTH-1:0]      diff,
    output logic [OUT_VALUE_WIDTH-1:0] value
);

    localparam int LUT_SIZE = 1 << IN_FRAC_WIDTH;

    logic [OUT_VALUE_WIDTH-1:0] lut [LUT_SIZE];
    logic [IN_FRAC_WIDTH-1:0]   frac_s;
    logic signed [DIFF_WIDTH-1:0] quot_s;
    logic [DIFF_WIDTH-1:0]      shift_s;

    for (genvar g = 0; g < LUT_SIZE; g++) begin : g_lut
        localparam logic [OUT_VALUE_WIDTH-1:0] ENTRY =
            OUT_VALUE_WIDTH'(pow2_lut_entry(g, IN_FRAC_WIDTH, OUT_VALUE_WIDTH));
        assign lut[g] = ENTRY;
    end

    // Table lookup on the fraction, then a truncating shift by the integer part.
    always_comb begin
        frac_s  = diff[IN_FRAC_WIDTH-1:0];
        quot_s  = $signed(diff) >>> IN_FRAC_WIDTH;
        // diff is never positive, so -quot is a non-negative shift count.
        shift_s = -quot_s;
        if (shift_s >= DIFF_WIDTH'(OUT_VALUE_WIDTH)) begin
            value = '0;
        end else begin
            value = lut[frac_s] >> shift_s;
        end
    end

endmodule

// File: rtl/softermax_local_window.sv
// softermax_local_window
// Local-max / pow2 front end of the softermax pipeline. Per beat of
// PARALLELISM signed logits it emits the ceiling of the lane maximum
// (out_max) and 2^(x_i - out_max) per lane as unsigned values in [0, 2).
// Three registered stages with valid/ready handshake:
//   S0 input register, S1 max + ceiling + subtract, S2 pow2 + shift.
// Optional build macro SOFTERMAX_LOCAL_WINDOW_MASK_EN adds in_mask: masked
// lanes are left out of the max and produce 0; an all-masked beat yields the
// most negative out_max and all-zero values.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_data/in_valid/in_ready      input beat and handshake
//   in_mask               per-lane exclusion (mask build only)
//   out_values/out_max/out_valid/out_ready  output beat and handshake
module softermax_local_window
    import softermax_pkg::*;
#(
    parameter int  PARALLELISM     = 4,
    parameter int  IN_WIDTH        = 8,
    parameter int  IN_FRAC_WIDTH   = 4,
    parameter int  OUT_VALUE_WIDTH = 16,
    localparam int OUT_MAX_WIDTH   = out_max_width(IN_WIDTH, IN_FRAC_WIDTH)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [PARALLELISM-1:0][IN_WIDTH-1:0]        in_data,
`ifdef SOFTERMAX_LOCAL_WINDOW_MASK_EN
    input  logic [PARALLELISM-1:0]                      in_mask,
`endif
    input  logic                                        in_valid,
    output logic                                        in_ready,
    output logic [PARALLELISM-1:0][OUT_VALUE_WIDTH-1:0] out_values,
    output logic [OUT_MAX_WIDTH-1:0]                    out_max,
    output logic                                        out_valid,
    input  logic                                        out_ready
);

    localparam int DIFF_WIDTH = IN_WIDTH + 2;

    logic                                        s0_valid_r;
    logic                                        s1_valid_r;
    logic                                        s2_valid_r;
    logic                                        ready_s1_s;
    logic                                        ready_s2_s;
    logic [PARALLELISM-1:0]                      mask_in_s;
    logic [PARALLELISM-1:0][IN_WIDTH-1:0]        s0_data_r;
    logic [PARALLELISM-1:0]                      s0_mask_r;
    logic [PARALLELISM-1:0][DIFF_WIDTH-1:0]      s1_diff_r;
    logic [PARALLELISM-1:0]                      s1_mask_r;
    logic [OUT_MAX_WIDTH-1:0]                    s1_max_r;
    logic signed [IN_WIDTH-1:0]                  lane_max_s;
    logic                                        any_lane_s;
    logic signed [IN_WIDTH:0]                    max_round_s;
    logic [OUT_MAX_WIDTH-1:0]                    max_ceil_s;
    logic [PARALLELISM-1:0][DIFF_WIDTH-1:0]      diff_s;
    logic [PARALLELISM-1:0][OUT_VALUE_WIDTH-1:0] pow_s;

`ifdef SOFTERMAX_LOCAL_WINDOW_MASK_EN
    assign mask_in_s = in_mask;
`else
    assign mask_in_s = '0;
`endif

    assign out_valid = s2_valid_r;

    // Backward ready chain: a stage accepts when empty or when its successor accepts.
    always_comb begin
        ready_s2_s = !s2_valid_r || out_ready;
        ready_s1_s = !s1_valid_r || ready_s2_s;
        in_ready   = !s0_valid_r || ready_s1_s;
    end

    // Lane max over unmasked lanes, ceiling to an integer, and per-lane difference.
    always_comb begin
        lane_max_s = {1'b1, {(IN_WIDTH-1){1'b0}}};
        any_lane_s = 1'b0;
        for (int i = 0; i < PARALLELISM; i++) begin
            if (!s0_mask_r[i] && (!any_lane_s || $signed(s0_data_r[i]) > lane_max_s)) begin
                lane_max_s = $signed(s0_data_r[i]);
                any_lane_s = 1'b1;
            end else begin
                any_lane_s = any_lane_s;
            end
        end
        // One extra integer bit absorbs the carry of the rounding-up add.
        max_round_s = {lane_max_s[IN_WIDTH-1], lane_max_s}
                    + (IN_WIDTH+1)'((1 << IN_FRAC_WIDTH) - 1);
        if (any_lane_s) begin
            max_ceil_s = OUT_MAX_WIDTH'(max_round_s >>> IN_FRAC_WIDTH);
        end else begin
            max_ceil_s = {1'b1, {(OUT_MAX_WIDTH-1){1'b0}}};
        end
        for (int i = 0; i < PARALLELISM; i++) begin
            diff_s[i] = DIFF_WIDTH'($signed(s0_data_r[i]))
                      - (DIFF_WIDTH'($signed(max_ceil_s)) << IN_FRAC_WIDTH);
        end
    end

    for (genvar g = 0; g < PARALLELISM; g++) begin : g_lane
        softermax_pow2_shift #(
            .IN_FRAC_WIDTH   (IN_FRAC_WIDTH),
            .OUT_VALUE_WIDTH (OUT_VALUE_WIDTH),
            .DIFF_WIDTH      (DIFF_WIDTH)
        ) u_pow2 (
            .diff  (s1_diff_r[g]),
            .value (pow_s[g])
        );
    end

    // S0: capture the incoming beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_r <= 1'b0;
            s0_data_r  <= '0;
            s0_mask_r  <= '0;
        end else if (in_ready) begin
            s0_valid_r <= in_valid;
            if (in_valid) begin
                s0_data_r <= in_data;
                s0_mask_r <= mask_in_s;
            end
        end
    end

    // S1: register integer max and per-lane differences.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_diff_r  <= '0;
            s1_mask_r  <= '0;
            s1_max_r   <= '0;
        end else if (ready_s1_s) begin
            s1_valid_r <= s0_valid_r;
            if (s0_valid_r) begin
                s1_diff_r <= diff_s;
                s1_mask_r <= s0_mask_r;
                s1_max_r  <= max_ceil_s;
            end
        end
    end

    // S2: register pow2 values (masked lanes forced to zero) and the max.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            out_values <= '0;
            out_max    <= '0;
        end else if (ready_s2_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                for (int i = 0; i < PARALLELISM; i++) begin
                    out_values[i] <= s1_mask_r[i] ? '0 : pow_s[i];
                end
                out_max <= s1_max_r;
            end
        end
    end

endmodule

// File: doc/softermax_local_window.md
Name: softermax_local_window

Overview:
- First section of the softermax pipeline; produces the input stream consumed by the global-normalisation stage.
- Each beat carries PARALLELISM signed fixed-point logits. For every beat the block:
  - computes the integer local max as the ceiling of the lane maximum;
  - outputs that max together with 2^(x_i - max) per lane, as unsigned fixed-point values in [0, 2).
- Corresponds to the top half of the Softermax local-max / pow2 datapath.

Parameters:
- PARALLELISM, 4, lanes per beat.
- IN_WIDTH, 8, signed input width.
- IN_FRAC_WIDTH, 4, input fraction bits; must be at least 1.
- OUT_VALUE_WIDTH, 16, output value width; fraction width is fixed at OUT_VALUE_WIDTH-1.
- OUT_MAX_WIDTH (localparam), IN_WIDTH-IN_FRAC_WIDTH+1, signed integer max width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_data  in  [IN_WIDTH-1:0] x PARALLELISM  signed logits
- in_valid  in  1  input handshake
- in_ready  out  1  input handshake
- out_values  out  [OUT_VALUE_WIDTH-1:0] x PARALLELISM  unsigned values in [0, 2)
- out_max  out  [OUT_MAX_WIDTH-1:0]  signed integer local max
- out_valid  out  1  output handshake
- out_ready  in  1  output handshake

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: all stage valids = 0, so out_valid = 0. Data registers reset to 0, so out_values = 0 and out_max = 0.
- Pipeline structure: three registered stages.
  - S0: input register.
  - S1: max, ceiling and subtract.
  - S2: pow2 and shift.
- Latency and throughput: latency is 3 cycles from an accepted beat to out_valid. Throughput is 1 beat/cycle.
- Stage handshake:
  - Each stage k loads when !valid_k || ready_{k+1}.
  - in_ready = !valid_S0 || ready_S1. A combinational ready chain is allowed.
  - No beat is dropped or duplicated.
  - While out_valid && !out_ready, out_values and out_max hold stable.
- Max:
  - m = signed maximum over the lanes.
  - out_max = (m + 2^IN_FRAC_WIDTH - 1) >>> IN_FRAC_WIDTH, using arithmetic shift (ceiling).
  - OUT_MAX_WIDTH covers the +1 overflow of the ceiling, e.g. 7.9375 -> 8.
- Subtract:
  - d_i = x_i - (out_max << IN_FRAC_WIDTH), signed, width IN_WIDTH+2.
  - d_i <= 0 always.
- Pow2:
  - q = d_i >>> IN_FRAC_WIDTH (floor); f = d_i[IN_FRAC_WIDTH-1:0]; shift s = -q.
  - out_values[i] = LUT[f] >> s, using a logical shift that truncates.
  - If s >= OUT_VALUE_WIDTH, the output is 0.
- LUT:
  - 2^IN_FRAC_WIDTH entries; LUT[f] = round-half-up(2^(f/2^IN_FRAC_WIDTH) * 2^(OUT_VALUE_WIDTH-1)).
  - LUT[0] = 2^(OUT_VALUE_WIDTH-1), which represents 1.0.
- Boundary conditions:
  - The lane holding the max always outputs a value in (0.5, 1.0].
  - All-equal lanes on an integer value output exactly 1.0 on every lane.
- Reset mid-operation: all in-flight beats are discarded, and out_valid = 0 on the next cycle.

Optional Feature:
- Macro: SOFTERMAX_LOCAL_WINDOW_MASK_EN.
- When defined:
  - Adds port in_mask (input, PARALLELISM bits), captured with in_data in S0.
  - A lane with mask bit 1 is excluded from the max and its out_values lane is forced to 0.
  - If all lanes are masked, out_max = the most negative OUT_MAX_WIDTH value and all values are 0.
- When undefined: no in_mask port; all lanes participate.

Decomposition:
- Package softermax_pkg holds:
  - the function that builds the pow2 LUT constant from (IN_FRAC_WIDTH, OUT_VALUE_WIDTH);
  - the OUT_MAX_WIDTH width-derivation function.
- One natural sub-module, softermax_pow2_shift: combinational LUT lookup plus shift and underflow-to-zero, instantiated once per lane.

Test Plan:
- Mixed lanes, defaults. Input [1.0, 0.5, -2.0, 0.25] (raw 16, 8, -32, 4) -> out_max = 1; out_values = [32768, 23170, 4096, 19484], where 46341>>1 = 23170 and 38968>>1 = 19484.
- Ceiling overflow and underflow. Input [7.9375, -8.0, -8.0, -8.0] -> out_max = 8; lane0 = LUT[15]>>1; lanes 1-3 = 0, since s = 16 >= OUT_VALUE_WIDTH.
- All-negative equal lanes. Input all -8.0 -> out_max = -8; all out_values = 32768.
- Back-pressure. 10 random beats streamed with out_ready toggling per a random pattern -> outputs match the golden model in order; outputs stable while stalled; in_ready deasserts once all three stages are full.
- Reset mid-stream. Assert rst for 1 cycle while 3 beats are in flight -> out_valid = 0 next cycle; no stale beat appears later; first post-reset beat emerges 3 cycles after acceptance.
- Mask (SOFTERMAX_LOCAL_WINDOW_MASK_EN defined):
  - Input [1.0, 3.0, 0, 0] with mask 0b0010 -> out_max = 1; lane1 = 0; lane0 = 32768.
  - Mask 0b1111 -> out_max = -16; all values 0.
